// File: rtl/cpu_pkg.sv
// Shared definitions for param_cpu_core: opcodes, control-bus layout,
// FSM state encoding and status-flag bit positions.
package cpu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_LOAD = 3'b111;

  localparam int CTRL_OP_HI  = 7;
  localparam int CTRL_OP_LO  = 5;
  localparam int CTRL_DST_HI = 4;
  localparam int CTRL_DST_LO = 3;
  localparam int CTRL_SRC_HI = 2;
  localparam int CTRL_SRC_LO = 1;
  localparam int CTRL_BSEL   = 0;

  localparam int NUM_REGS = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int F_Z = 3;
  localparam int F_C = 2;
  localparam int F_N = 1;
  localparam int F_V = 0;

  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    logic [3:0] f;
    f      = '0;
    f[F_Z] = z;
    f[F_C] = c;
    f[F_N] = n;
    f[F_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Single-cycle combinational ALU: ADD/SUB/AND/OR/XOR/LOAD with carry and
// signed-overflow outputs. Z and N are derived by the caller.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             v_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // The extra top bit of a zero-extended subtraction is the unsigned borrow.
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    res_o = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o = sum[WIDTH-1:0];
        c_o   = sum[WIDTH];
        v_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res_o = diff[WIDTH-1:0];
        c_o   = diff[WIDTH];
        v_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_LOAD: res_o = a_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/param_cpu_core.sv
// WIDTH-bit CPU core: 4-entry register file, registered result/flags,
// valid/ready intake and a shift-add multiplier taking WIDTH cycles.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [7:0]       in_ctrl_bus,
  input  logic             in_valid,
  output logic             out_ready,
  output logic [WIDTH-1:0] out_Q,
  output logic [3:0]       out_flags,
  output logic             out_valid
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   regs_q [NUM_REGS];
  logic [WIDTH-1:0]   q_q, q_d;
  logic [3:0]         flags_q, flags_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         dest_q, dest_d;

  logic [2:0]         op;
  logic [1:0]         dst;
  logic [1:0]         src;
  logic               bsel;
  logic [WIDTH-1:0]   operand_b;
  logic               accept;
  logic               in_mul;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   wb_res;
  logic               wb_c;
  logic               wb_v;
  logic [3:0]         wb_flags;
  logic               wr_en;
  logic [1:0]         wr_idx;

  assign op   = in_ctrl_bus[CTRL_OP_HI:CTRL_OP_LO];
  assign dst  = in_ctrl_bus[CTRL_DST_HI:CTRL_DST_LO];
  assign src  = in_ctrl_bus[CTRL_SRC_HI:CTRL_SRC_LO];
  assign bsel = in_ctrl_bus[CTRL_BSEL];

  assign operand_b = bsel ? regs_q[src] : in_B;
  assign out_ready = (state_q == ST_IDLE) && in_rst_n;
  assign accept    = in_valid && out_ready;
  assign in_mul    = (state_q == ST_MUL);

  cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i  (op),
    .a_i   (in_A),
    .b_i   (operand_b),
    .res_o (alu_res),
    .c_o   (alu_c),
    .v_o   (alu_v)
  );

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // One writeback path serves both the ALU and the multiplier so Z/N logic is shared.
  assign wb_res   = in_mul ? acc_sum[WIDTH-1:0] : alu_res;
  assign wb_c     = in_mul ? |acc_sum[2*WIDTH-1:WIDTH] : alu_c;
  assign wb_v     = in_mul ? 1'b0 : alu_v;
  assign wb_flags = pack_flags(wb_res == '0, wb_c, wb_res[WIDTH-1], wb_v);

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = dst;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, in_A};
            mplier_d = operand_b;
            acc_d    = '0;
            cnt_d    = '0;
            dest_d   = dst;
            state_d  = ST_MUL;
          end else begin
            valid_d = 1'b1;
            if (op != OP_NOP) begin
              q_d     = wb_res;
              flags_d = wb_flags;
              wr_en   = 1'b1;
            end
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The final iteration's sum is committed directly, saving a cycle.
        if (cnt_q == LAST_ITER) begin
          valid_d = 1'b1;
          q_d     = wb_res;
          flags_d = wb_flags;
          wr_en   = 1'b1;
          wr_idx  = dest_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wb_res;
    end
  end

  assign out_Q     = q_q;
  assign out_flags = flags_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_param_cpu_core.sv
// Self-checking bench for param_cpu_core (WIDTH=4): directed scenarios plus
// random instructions compared against an arithmetic reference model.
module tb_param_cpu_core;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic [7:0]       in_ctrl_bus;
  logic             in_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_Q;
  logic [3:0]       out_flags;
  logic             out_valid;

  int checks   = 0;
  int failures = 0;

  int mregs [4];
  int mq;
  int mflags;

  param_cpu_core #(.WIDTH(WIDTH)) dut (
    .in_clk      (clk),
    .in_rst_n    (rst_n),
    .in_A        (in_A),
    .in_B        (in_B),
    .in_ctrl_bus (in_ctrl_bus),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .out_Q       (out_Q),
    .out_flags   (out_flags),
    .out_valid   (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics from plain integer arithmetic; flags packed as Z*8+C*4+N*2+V.
  function automatic void model_exec(input int op, input int a, input int b,
                                     output int res, output int fl);
    int  m, half, raw, sa, sb, s;
    bit  z, c, n, v;
    m    = 1 << WIDTH;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    c    = 1'b0;
    v    = 1'b0;
    res  = 0;
    case (op)
      1: begin
        raw = a + b;
        res = raw % m;
        c   = (raw >= m);
        s   = sa + sb;
        v   = (s >= half) || (s < -half);
      end
      2: begin
        res = (a - b + m) % m;
        c   = (a < b);
        s   = sa - sb;
        v   = (s >= half) || (s < -half);
      end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: begin
        raw = a * b;
        res = raw % m;
        c   = (raw >= m);
      end
      7: res = a;
      default: res = 0;
    endcase
    z  = (res == 0);
    n  = (res >= half);
    fl = (z ? 8 : 0) + (c ? 4 : 0) + (n ? 2 : 0) + (v ? 1 : 0);
  endfunction

  task automatic apply_reset(input int cycles, input string tag);
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_A        = 4'($urandom);
    in_B        = 4'($urandom);
    in_ctrl_bus = 8'($urandom);
    #1;
    check({tag, "_rdy_in_rst"}, 32'(out_ready), 32'd0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_rdy"},   32'(out_ready), 32'd0);
      check({tag, "_q"},     32'(out_Q),     32'd0);
      check({tag, "_flags"}, 32'(out_flags), 32'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    mq       = 0;
    mflags   = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check({tag, "_rdy_release"}, 32'(out_ready), 32'd1);
    @(posedge clk); #1;
    check({tag, "_no_spurious_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_after"},         32'(out_ready), 32'd1);
  endtask

  task automatic idle_cycle(input string tag);
    in_valid = 1'b0;
    in_A     = 4'($urandom);
    in_B     = 4'($urandom);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_q"},     32'(out_Q),     32'(mq));
    check({tag, "_flags"}, 32'(out_flags), 32'(mflags));
    check({tag, "_rdy"},   32'(out_ready), 32'd1);
  endtask

  task automatic issue(input int a, input int b, input logic [7:0] ctrl, input string tag);
    int op, dst, src, bval, res, fl;
    op   = int'(ctrl[7:5]);
    dst  = int'(ctrl[4:3]);
    src  = int'(ctrl[2:1]);
    bval = ctrl[0] ? mregs[src] : b;
    model_exec(op, a, bval, res, fl);
    check({tag, "_rdy_pre"}, 32'(out_ready), 32'd1);
    in_valid    = 1'b1;
    in_A        = 4'(a);
    in_B        = 4'(b);
    in_ctrl_bus = ctrl;
    @(posedge clk); #1;
    if (op == 6) begin
      for (int i = 0; i < WIDTH; i++) begin
        check({tag, "_busy_rdy"},   32'(out_ready), 32'd0);
        check({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
        in_valid    = 1'($urandom_range(0, 1));
        in_A        = 4'($urandom);
        in_B        = 4'($urandom);
        in_ctrl_bus = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (op != 0) begin
      mregs[dst] = res;
      mq         = res;
      mflags     = fl;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_q"},     32'(out_Q),     32'(mq));
    check({tag, "_flags"}, 32'(out_flags), 32'(mflags));
    check({tag, "_rdy"},   32'(out_ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_A        = '0;
    in_B        = '0;
    in_ctrl_bus = '0;
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    mq     = 0;
    mflags = 0;

    apply_reset(2, "reset");

    issue(4'b1101, 0, 8'b11101000, "load");
    check("load_q_const",     32'(out_Q),     32'b1101);
    check("load_flags_const", 32'(out_flags), 32'b0010);

    issue(4'b0011, 0, 8'b00110011, "add");
    check("add_q_const",     32'(out_Q),     32'b0000);
    check("add_flags_const", 32'(out_flags), 32'b1100);

    issue(0, 0, 8'b10000101, "read_r2");
    check("r2_const", 32'(out_Q), 32'b0000);

    issue(4'b0111, 4'b1111, 8'b01000000, "sub_ovf");
    check("sub_q_const",     32'(out_Q),     32'b1000);
    check("sub_flags_const", 32'(out_flags), 32'b0111);

    issue(4'b0110, 4'b0011, 8'b11011000, "mul");
    check("mul_q_const",     32'(out_Q),     32'b0010);
    check("mul_flags_const", 32'(out_flags), 32'b0100);
    idle_cycle("mul_single_pulse");

    // Abort a MUL after its first iteration.
    in_valid    = 1'b1;
    in_A        = 4'b0110;
    in_B        = 4'b0011;
    in_ctrl_bus = 8'b11011000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_rdy", 32'(out_ready), 32'd0);
    @(posedge clk); #1;
    check("abort_valid_iter1", 32'(out_valid), 32'd0);
    apply_reset(1, "abort_rst");
    idle_cycle("abort_quiet");
    issue(4'b0000, 0, 8'b00100111, "add_r3");
    check("add_r3_q_const",     32'(out_Q),     32'b0000);
    check("add_r3_flags_const", 32'(out_flags), 32'b1000);

    issue(4'b0101, 0, 8'b11100000, "b2b_load");
    check("b2b_load_q_const", 32'(out_Q), 32'b0101);
    issue(4'b0001, 0, 8'b00101001, "b2b_add");
    check("b2b_add_q_const", 32'(out_Q), 32'b0110);
    issue(4'b1111, 0, 8'b10110011, "b2b_xor");
    check("b2b_xor_q_const", 32'(out_Q), 32'b1001);
    idle_cycle("b2b_end");

    for (int t = 0; t < 300; t++) begin
      int sel;
      sel = $urandom_range(0, 49);
      if (sel == 0) begin
        apply_reset(1, "rnd_rst");
      end else if (sel < 10) begin
        idle_cycle("rnd_idle");
      end else begin
        issue($urandom_range(0, 15), $urandom_range(0, 15), 8'($urandom), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_cpu_core.md
# param_cpu_core

Parametrised successor to the 4-bit `top` CPU block: a WIDTH-bit datapath with a 4-entry register file, status flags, a valid/ready input handshake and a multi-cycle shift-add multiplier. It keeps the A/B operand inputs, the 8-bit control bus and the single registered result output. It sits between the instruction/operand source and the result consumer.

## Interface
- `WIDTH`, 4, operand/result/register width; must be ≥ 2.
- `in_clk` input 1: clock; all state updates on the rising edge.
- `in_rst_n` input 1: reset, synchronous, active-low.
- `in_A` input WIDTH: operand A.
- `in_B` input WIDTH: operand B (immediate).
- `in_ctrl_bus` input 8: `[7:5]` opcode, `[4:3]` dest reg, `[2:1]` src reg, `[0]` B-select (0 = `in_B`, 1 = `reg[src]`).
- `in_valid` input 1: instruction present on `in_A`/`in_B`/`in_ctrl_bus`.
- `out_ready` output 1: block can accept; equals (state==IDLE) && `in_rst_n`.
- `out_Q` output WIDTH: last result (registered).
- `out_flags` output 4: `{Z, C, N, V}` (registered).
- `out_valid` output 1: one-cycle pulse, `out_Q`/`out_flags` updated this cycle.

## Operation
- Accept = `in_valid && out_ready` at a rising edge; operands sampled at that edge.
- Opcodes:
  - 000 NOP: `out_Q`/flags unchanged; `out_valid` still pulses.
  - 001 ADD: A+B.
  - 010 SUB: A−B.
  - 011 AND, 100 OR, 101 XOR.
  - 110 MUL: multi-cycle.
  - 111 LOAD: result = `in_A`; B ignored.
- Every opcode except NOP writes its result to `reg[dest]` and `out_Q`.
- Result is WIDTH bits; the carry/high half is discarded into flags.
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (A<B unsigned); V = signed overflow.
  - Logic ops and LOAD: C = V = 0.
  - MUL: C = (high half of the 2·WIDTH product ≠ 0); V = 0.
- FSM states IDLE, MUL:
  - IDLE + accepted non-MUL: execute in one cycle; stay in IDLE.
  - IDLE + accepted MUL: latch multiplicand A and multiplier B; clear accumulator; clear iteration counter; go to MUL.
  - MUL, each cycle: if multiplier LSB is set, add the shifted multiplicand to the accumulator; shift; increment counter.
  - MUL, after WIDTH iterations: write result and flags, pulse `out_valid`, return to IDLE.
- `in_valid` while in MUL is ignored (not accepted, not queued).
- src==dest in one instruction: reads the old value, writes the new.
- Reset (`in_rst_n`=0 at an edge): regs 0, `out_Q`=0, `out_flags`=0, `out_valid`=0, state IDLE, counter 0. Reset has priority over everything, including mid-MUL abort (no register write).

## Timing
- Single-cycle ops:
  - Accepted at edge k → `out_Q`/flags/`reg[dest]` updated and `out_valid`=1 after edge k.
  - Throughput 1 instruction/cycle.
- RAW on the next cycle sees the updated register (write at edge k, read for edge k+1).
- MUL:
  - Accepted at edge k → `out_ready`=0 after edges k..k+WIDTH−1.
  - Result, flags and `out_valid`=1 after edge k+WIDTH; `out_ready`=1 in that same cycle.
- `out_valid` is never high two cycles for one instruction.
- `out_valid` stays 0 while in MUL before the final iteration.
- `out_ready`=0 throughout any cycle with `in_rst_n`=0.

## Structure
- Package `cpu_pkg`:
  - Opcode localparams (`OP_NOP`…`OP_LOAD`).
  - Control-bus field bit positions.
  - FSM state encoding.
  - Flag bit indices (`F_Z`=3, `F_C`=2, `F_N`=1, `F_V`=0).
- Sub-module `cpu_alu` (combinational, WIDTH-parametrised):
  - Covers ADD/SUB/AND/OR/XOR/LOAD.
  - Outputs result and C, V.
  - Z and N are derived in the core so MUL shares them.
- Core holds the register file, FSM, multiplier accumulator/counter and output registers.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold `in_rst_n`=0 for 2 cycles with `in_valid`=1 → `out_ready`=0, `out_Q`=0000, `out_flags`=0000, `out_valid`=0; release → `out_ready`=1 and no spurious `out_valid`.
- LOAD then ADD:
  - `in_A`=1101, ctrl 8'b11101000 → `out_Q`=1101, flags Z0 C0 N1 V0.
  - Next cycle `in_A`=0011, ctrl 8'b00110011 → `out_Q`=0000, flags Z1 C1 N0 V0; r2=0000.
- SUB overflow: `in_A`=0111, `in_B`=1111, ctrl 8'b01000000 → `out_Q`=1000, flags Z0 C1 N1 V1.
- MUL: `in_A`=0110, `in_B`=0011, ctrl 8'b11011000:
  - `out_ready`=0 for 4 cycles.
  - `out_valid` exactly 4 edges after accept, `out_Q`=0010, flags C1 Z0 N0 V0.
  - `in_valid` pulse mid-MUL ignored.
- Reset mid-MUL: start the MUL above, assert `in_rst_n`=0 at iteration 2 → no `out_valid`; afterwards ADD `in_A`=0000 + r3 (ctrl 8'b00100111) gives `out_Q`=0000, Z1.
- Back-to-back: LOAD r0=0101, ADD r1=`in_A` 0001+r0, XOR r2=`in_A` 1111^r1 on consecutive cycles → `out_valid` high 3 consecutive cycles, `out_Q` 0101, 0110, 1001.
